// File: rtl/fetch_queue.sv
// Instruction-fetch front end: one outstanding read on port A, DEPTH-entry {pc, instr} prefetch queue,
// decode back-pressure and redirect/flush. Optional same-cycle bypass with FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         read_a,
  output logic [31:0]                  address_a,
  input  logic                         resp_a,
  input  logic [31:0]                  rdata_a,
  input  logic                         redirect,
  input  logic [31:0]                  redirect_pc,
  input  logic                         stall,
  output logic                         valid_out,
  output logic [31:0]                  instruction_out,
  output logic [31:0]                  pc_out,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t [DEPTH-1:0] mem;
  logic [PW-1:0]      head, tail;
  logic [1:0]         state;
  logic [31:0]        fetch_pc;

  logic [31:0]   rpc, next_pc;
  logic          q_empty, resp_ok, bypass, byp_take, q_pop, q_push, room;
  logic [CW-1:0] cnt_nxt;

  assign rpc     = {redirect_pc[31:2], 2'b00};
  assign next_pc = fetch_pc + 32'd4;
  assign q_empty = (count == '0);
  // Only a response to a live (non-stale) request that isn't being flushed is accepted.
  assign resp_ok = (state == S_REQ) && resp_a && !redirect;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = resp_ok && q_empty;
`else
  assign bypass = 1'b0;
`endif

  assign byp_take = bypass && !stall;
  assign q_pop    = !q_empty && !stall && !redirect;
  assign q_push   = resp_ok && !byp_take;
  assign cnt_nxt  = redirect ? '0 : count + CW'(q_push) - CW'(q_pop);
  assign room     = (cnt_nxt < DEPTH_C);

  always_comb begin
    valid_out       = 1'b0;
    instruction_out = '0;
    pc_out          = '0;
    if (!q_empty) begin
      valid_out       = 1'b1;
      instruction_out = mem[head].instr;
      pc_out          = mem[head].pc;
    end else if (bypass) begin
      valid_out       = 1'b1;
      instruction_out = rdata_a;
      pc_out          = address_a;
    end
  end

  // Queue storage carries no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (q_push) mem[tail] <= '{pc: address_a, instr: rdata_a};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (q_pop)  head <= head + PW'(1);
      if (q_push) tail <= tail + PW'(1);
      count <= cnt_nxt;
    end
  end

  // A request is issued only once a slot is reserved, so a push can never overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      read_a    <= 1'b0;
      address_a <= RESET_PC;
      fetch_pc  <= RESET_PC;
    end else begin
      case (state)
        S_IDLE: begin
          if (redirect) begin
            fetch_pc  <= rpc;
            address_a <= rpc;
            read_a    <= 1'b1;
            state     <= S_REQ;
          end else if (room) begin
            address_a <= fetch_pc;
            read_a    <= 1'b1;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (redirect) begin
            fetch_pc <= rpc;
            if (resp_a) address_a <= rpc;
            else        state     <= S_DRAIN;
          end else if (resp_a) begin
            fetch_pc <= next_pc;
            if (room) begin
              address_a <= next_pc;
            end else begin
              read_a <= 1'b0;
              state  <= S_IDLE;
            end
          end
        end
        S_DRAIN: begin
          // Stale address stays on the port until memory answers; that word is dropped.
          if (redirect) begin
            fetch_pc <= rpc;
            if (resp_a) begin
              address_a <= rpc;
              state     <= S_REQ;
            end
          end else if (resp_a) begin
            address_a <= fetch_pc;
            state     <= S_REQ;
          end
        end
        default: begin
          read_a <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) count <= DEPTH_C);

endmodule
